arb_mux_2_1: RTL and testbench



---
 rtl/arb_pkg.sv | 25 ++
 rtl/mux_2_1.sv | 16 +
 rtl/arb_mux_2_1.sv | 148 ++++++++++++++
 tb/tb_arb_mux_2_1.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the two-source round-robin arbiter and its datapath mux.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable; sources hold their request level until granted.
package arb_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT1 = 2'd1,
        ST_GNT2 = 2'd2
    } arb_state_t;

    // Source identifiers, used for the round-robin "last served" register.
    localparam logic [1:0] SRC_1 = 2'd1;
    localparam logic [1:0] SRC_2 = 2'd2;

    // Width of the consecutive-grant hold counter.
    localparam int CNT_W = 8;

    // Source identifier that owns a given grant state.
    function automatic logic [1:0] state_src(input arb_state_t st);
        state_src = (st == ST_GNT1) ? SRC_1 : SRC_2;
    endfunction

endpackage

// File: rtl/mux_2_1.sv
// 1-bit 2:1 data mux: sel=1 routes in_1, sel=0 routes in_2.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output always reflects the current inputs.
module mux_2_1 (
    input  logic sel,
    input  logic in_1,
    input  logic in_2,
    output logic out
);

    // Select between the two data bits.
    always_comb begin
        out = sel ? in_1 : in_2;
    end

endmodule

// File: rtl/arb_mux_2_1.sv
// Round-robin arbiter owning the select of a 2:1 mux; optional hold limit under ARB_HOLD_LIMIT_EN.
// Latency: grant 1 cycle after request, release 1 cycle after request drop; out is combinational.
// Backpressure: a source keeps its request level until served; losers simply wait for a grant.
module arb_mux_2_1
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req_1,
    input  logic req_2,
    input  logic in_1,
    input  logic in_2,
    output logic gnt_1,
    output logic gnt_2,
    output logic sel,
    output logic busy,
    output logic out
);

    // Reject hold limits the 8-bit counter cannot represent.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arb_mux_2_1: MAX_HOLD must be within 1..255");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] r_last;
    logic       r_gnt_1;
    logic       r_gnt_2;
    logic       r_sel;
    logic       w_sel_nxt;
    logic       w_entry;
    logic       w_hold_done;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Hold counter: zero on each grant entry, counts grant cycles, saturates at the limit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (w_entry) begin
            r_cnt <= '0;
        end else if (r_state != ST_IDLE && r_cnt != HOLD_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Current owner has used its full share of consecutive cycles.
    always_comb begin
        w_hold_done = (r_cnt == HOLD_LAST);
    end
`else
    // Without the limit a grant lasts until its own request drops.
    always_comb begin
        w_hold_done = 1'b0;
    end
`endif

    // Next-state and select decode; a contended handover goes straight to the other grant.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_entry     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_1 && (!req_2 || r_last == SRC_2)) begin
                    w_state_nxt = ST_GNT1;
                end else if (req_2) begin
                    w_state_nxt = ST_GNT2;
                end
            end
            ST_GNT1: begin
                if (!req_1) begin
                    w_state_nxt = req_2 ? ST_GNT2 : ST_IDLE;
                end else if (req_2 && w_hold_done) begin
                    w_state_nxt = ST_GNT2;
                end
            end
            ST_GNT2: begin
                if (!req_2) begin
                    w_state_nxt = req_1 ? ST_GNT1 : ST_IDLE;
                end else if (req_1 && w_hold_done) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Select follows the granted source; IDLE leaves it where it was.
        if (w_state_nxt == ST_GNT1) begin
            w_sel_nxt = 1'b1;
        end else if (w_state_nxt == ST_GNT2) begin
            w_sel_nxt = 1'b0;
        end

        w_entry = (w_state_nxt != ST_IDLE) && (w_state_nxt != r_state);
    end

    // State, grant and select registers all move on the same edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_gnt_1 <= 1'b0;
            r_gnt_2 <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt_1 <= (w_state_nxt == ST_GNT1);
            r_gnt_2 <= (w_state_nxt == ST_GNT2);
            r_sel   <= w_sel_nxt;
        end
    end

    // Remember who was granted most recently; reset favours source 1 on the first tie.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_last <= SRC_2;
        end else if (w_entry) begin
            r_last <= state_src(w_state_nxt);
        end
    end

    // Grants must never overlap.
    assert property (@(posedge sys_clk) !(r_gnt_1 && r_gnt_2));

    mux_2_1 u_mux (
        .sel  (r_sel),
        .in_1 (in_1),
        .in_2 (in_2),
        .out  (out)
    );

    // Drive registered outputs.
    always_comb begin
        gnt_1 = r_gnt_1;
        gnt_2 = r_gnt_2;
        sel   = r_sel;
        busy  = r_gnt_1 | r_gnt_2;
    end

endmodule

// File: tb/tb_arb_mux_2_1.sv
module tb_arb_mux_2_1;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic req_1   = 1'b0;
    logic req_2   = 1'b0;
    logic in_1    = 1'b0;
    logic in_2    = 1'b0;
    logic gnt_1;
    logic gnt_2;
    logic sel;
    logic busy;
    logic out;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    arb_mux_2_1 #(.MAX_HOLD(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req_1   (req_1),
        .req_2   (req_2),
        .in_1    (in_1),
        .in_2    (in_2),
        .gnt_1   (gnt_1),
        .gnt_2   (gnt_2),
        .sel     (sel),
        .busy    (busy),
        .out     (out)
    );

    always #5 sys_clk = ~sys_clk;

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input logic rst, input logic r1, input logic r2, input logic i1, input logic i2,
                        input logic eg1, input logic eg2, input logic esel, input string tag);
        @(negedge sys_clk);
        sys_rst = rst;
        req_1   = r1;
        req_2   = r2;
        in_1    = i1;
        in_2    = i2;
        exp_q.push_back({eg1, eg2, esel, eg1 | eg2, esel ? i1 : i2});
        tag_q.push_back(tag);
    endtask

    // Monitor: after each rising edge, compare presented outputs with the oldest expectation.
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        string      t;
        forever begin
            @(posedge sys_clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {gnt_1, gnt_2, sel, busy, out};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s @%0t: {gnt_1,gnt_2,sel,busy,out} got %b expected %b", t, $time, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic b;
        logic g2;

        // Reset held with both requesting: everything low, out follows in_2.
        step(1, 1, 1, 0, 1, 0, 0, 0, "reset_0");
        step(1, 1, 1, 1, 0, 0, 0, 0, "reset_1");
        // First tie after reset goes to source 1.
        step(0, 1, 1, 0, 1, 1, 0, 1, "first_tie");
        step(0, 0, 0, 1, 0, 0, 0, 1, "idle_sel_hold_a");
        step(0, 0, 0, 0, 1, 0, 0, 1, "idle_sel_hold_b");

        // Single requester 2 for 5 cycles.
        step(0, 0, 1, 0, 1, 0, 1, 0, "single2_0");
        step(0, 0, 1, 1, 0, 0, 1, 0, "single2_1");
        step(0, 0, 1, 0, 1, 0, 1, 0, "single2_2");
        step(0, 0, 1, 0, 1, 0, 1, 0, "single2_3");
        step(0, 0, 1, 1, 0, 0, 1, 0, "single2_4");
        step(0, 0, 0, 0, 1, 0, 0, 0, "single2_release");

        // Tie fairness: source 1 served then released, so the next tie goes to source 2.
        step(0, 1, 0, 1, 0, 1, 0, 1, "fair_g1");
        step(0, 0, 0, 1, 0, 0, 0, 1, "fair_idle");
        step(0, 1, 1, 1, 0, 0, 1, 0, "fair_tie_g2");

`ifdef ARB_HOLD_LIMIT_EN
        // Both held: 4-cycle turns alternating with no gap.
        for (int i = 1; i < 16; i++) begin
            b  = i[0];
            g2 = ((i / 4) % 2 == 0);
            step(0, 1, 1, b, ~b, ~g2, g2, ~g2, "contention");
        end
        step(0, 0, 1, 1, 0, 0, 1, 0, "release_switch");
        step(0, 0, 0, 1, 0, 0, 0, 0, "contention_idle");
`else
        // No limit: grant 2 is kept while both request.
        for (int i = 1; i < 6; i++) begin
            b = i[0];
            step(0, 1, 1, b, ~b, 0, 1, 0, "nolimit_hold2");
        end
        step(0, 1, 0, 1, 0, 1, 0, 1, "nolimit_switch1");
        for (int i = 1; i < 20; i++) begin
            b = i[0];
            step(0, 1, 1, b, ~b, 1, 0, 1, "nolimit_hold1");
        end
        step(0, 0, 1, 1, 0, 0, 1, 0, "nolimit_switch2");
        step(0, 0, 0, 1, 0, 0, 0, 0, "nolimit_idle");
`endif

        // Reset mid-grant with the counter at 2.
        step(0, 1, 0, 1, 0, 1, 0, 1, "midrst_g1_0");
        step(0, 1, 0, 0, 1, 1, 0, 1, "midrst_g1_1");
        step(0, 1, 0, 1, 0, 1, 0, 1, "midrst_g1_2");
        step(1, 1, 1, 1, 0, 0, 0, 0, "midrst_reset");
        // After release the tie goes to source 1 again, with a fresh counter.
        step(0, 1, 1, 0, 1, 1, 0, 1, "midrst_tie_g1");
        step(0, 1, 1, 1, 0, 1, 0, 1, "midrst_hold_1");
        step(0, 1, 1, 0, 1, 1, 0, 1, "midrst_hold_2");
        step(0, 1, 1, 1, 0, 1, 0, 1, "midrst_hold_3");
`ifdef ARB_HOLD_LIMIT_EN
        step(0, 1, 1, 1, 0, 0, 1, 0, "midrst_forced");
        step(0, 0, 0, 1, 0, 0, 0, 0, "final_idle");
`else
        step(0, 1, 1, 0, 1, 1, 0, 1, "midrst_kept");
        step(0, 0, 0, 1, 0, 0, 0, 1, "final_idle");
`endif

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge sys_clk);
        end
        #4;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
